// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if
// Upstream vector stream into the systolic array feeder.
//   s_valid_i  upstream has a vector on s_data_i
//   s_ready_o  feeder can take a vector this cycle
//   s_data_i   ARRAY_SIZE elements of DWIDTH bits, element r at [r*DWIDTH +: DWIDTH]
//   s_last_i   final vector of a job, meaningful only with s_valid_i
// master = upstream producer, slave = feeder.
interface systolic_feeder_if #(
    parameter int DWIDTH     = 8,
    parameter int ARRAY_SIZE = 16
);
    logic                         s_valid_i;
    logic                         s_ready_o;
    logic [ARRAY_SIZE*DWIDTH-1:0] s_data_i;
    logic                         s_last_i;

    modport master (
        output s_valid_i,
        output s_data_i,
        output s_last_i,
        input  s_ready_o
    );

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        input  s_last_i,
        output s_ready_o
    );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder
// Input-side sequencer for a weight-stationary systolic array. Takes
// activation vectors over a valid/ready stream, skews row r by r+1 cycles
// so the diagonal wavefront enters the array's left edge correctly, drives
// the array global enable, flushes zeros after the last vector of a job and
// produces a column-0 result-valid strobe aligned with the bottom edge.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   s_if         upstream vector stream (slave side)
//   input_o      skewed row inputs, row r at [r*DWIDTH +: DWIDTH]
//   enable_o     array global enable
//   res_valid_o  column-0 result of a real vector at the bottom edge
//   done_o       one-cycle pulse when a job has fully drained
// RES_LAT must be at least ARRAY_SIZE (and at least 2).
module systolic_feeder #(
    parameter int DWIDTH     = 8,
    parameter int ARRAY_SIZE = 16,
    parameter int RES_LAT    = 17
) (
    input  logic                         clk,
    input  logic                         reset_n,
    systolic_feeder_if.slave             s_if,
    output logic [ARRAY_SIZE*DWIDTH-1:0] input_o,
    output logic                         enable_o,
    output logic                         res_valid_o,
    output logic                         done_o
);

    localparam int FLUSH_LEN = RES_LAT + ARRAY_SIZE - 1;
    localparam int CNT_W     = $clog2(FLUSH_LEN + 1);
    // The counter holds the number of FLUSH cycles still to come after the
    // current one, so the first FLUSH cycle starts at FLUSH_LEN-1 and done_o
    // lands in the cycle the last column result reaches the bottom edge.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   flush_cnt;
    logic               load_cnt;
    logic               accept;
    logic               advance;
    logic [RES_LAT-1:0] tag_line;

    assign s_if.s_ready_o = (state != FLUSH);
    assign accept         = s_if.s_valid_i && s_if.s_ready_o;
    // Once a job has started every pipeline advances each cycle; in IDLE the
    // lines only move when a vector is taken, so they stay zero between jobs.
    assign advance        = accept || (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control outputs. A single-vector job goes from IDLE
    // straight to FLUSH.
    always_comb begin
        next_state = state;
        enable_o   = 1'b0;
        done_o     = 1'b0;
        load_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (s_if.s_last_i) begin
                        next_state = FLUSH;
                        load_cnt   = 1'b1;
                    end else begin
                        next_state = STREAM;
                    end
                end
            end
            STREAM: begin
                enable_o = 1'b1;
                if (accept && s_if.s_last_i) begin
                    next_state = FLUSH;
                    load_cnt   = 1'b1;
                end
            end
            FLUSH: begin
                enable_o = 1'b1;
                if (flush_cnt == '0) begin
                    done_o     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Flush counter, loaded on the edge that enters FLUSH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt <= '0;
        end else if (load_cnt) begin
            flush_cnt <= CNT_LOAD;
        end else if ((state == FLUSH) && (flush_cnt != '0)) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    // Tag line: marks which bottom-edge results come from real vectors
    // rather than zero bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_line <= '0;
        end else if (advance) begin
            tag_line <= {tag_line[RES_LAT-2:0], accept};
        end
    end

    assign res_valid_o = tag_line[RES_LAT-1];

    // Skew line: row r is an (r+1)-deep shift register. Non-accept shifts
    // push zeros, which contribute nothing to the column sums.
    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        logic [DWIDTH-1:0] pipe [0:r];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i <= r; i++) begin
                    pipe[i] <= '0;
                end
            end else if (advance) begin
                pipe[0] <= accept ? s_if.s_data_i[r*DWIDTH +: DWIDTH] : '0;
                for (int i = 1; i <= r; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign input_o[r*DWIDTH +: DWIDTH] = pipe[r];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder
// Self-checking bench for systolic_feeder. A job-level reference model
// (accept history keyed by cycle number plus job/flush bookkeeping) predicts
// every output each cycle; a table of spot values checks the back-to-back
// stream scenario explicitly.
module tb_systolic_feeder;

    localparam int DWIDTH     = 8;
    localparam int ARRAY_SIZE = 16;
    localparam int RES_LAT    = 17;
    localparam int VW         = DWIDTH * ARRAY_SIZE;
    localparam int FLUSH_LEN  = RES_LAT + ARRAY_SIZE - 1;

    logic          clk;
    logic          reset_n;
    logic [VW-1:0] input_o;
    logic          enable_o;
    logic          res_valid_o;
    logic          done_o;

    systolic_feeder_if #(.DWIDTH(DWIDTH), .ARRAY_SIZE(ARRAY_SIZE)) sf_if ();

    systolic_feeder #(
        .DWIDTH    (DWIDTH),
        .ARRAY_SIZE(ARRAY_SIZE),
        .RES_LAT   (RES_LAT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_if       (sf_if),
        .input_o    (input_o),
        .enable_o   (enable_o),
        .res_valid_o(res_valid_o),
        .done_o     (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: vector accepted at edge e (keyed by e), whether a job
    // is running, and the cycle in which the running job's done_o is due
    // (-1 while no FLUSH is pending).
    logic [VW-1:0] hist [int];
    bit            m_active   = 1'b0;
    int            m_done_cyc = -1;

    typedef struct {
        int         off;
        logic [7:0] row5;
        logic       res;
        logic       en;
        logic       dn;
    } spot_t;

    spot_t      spots [12];
    logic [7:0] rec_row5 [0:39];
    logic       rec_res  [0:39];
    logic       rec_en   [0:39];
    logic       rec_dn   [0:39];

    function automatic logic [VW-1:0] randVec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Row r shows, in cycle c, the element of the vector taken at edge c-1-r.
    function automatic logic [VW-1:0] expInput();
        logic [VW-1:0] v;
        v = '0;
        for (int r = 0; r < ARRAY_SIZE; r++) begin
            if (hist.exists(cyc - 1 - r)) begin
                v[r*DWIDTH +: DWIDTH] = hist[cyc - 1 - r][r*DWIDTH +: DWIDTH];
            end
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic exp_res;
        exp_res = hist.exists(cyc - RES_LAT) ? 1'b1 : 1'b0;
        chk("input_o", input_o, expInput());
        chk("res_valid_o", VW'(res_valid_o), VW'(exp_res));
        chk("enable_o", VW'(enable_o), VW'(m_active));
        chk("done_o", VW'(done_o), VW'(cyc == m_done_cyc));
        chk("s_ready_o", VW'(sf_if.s_ready_o), VW'(m_done_cyc < 0));
    endtask

    task automatic modelEdge(input logic v, input logic l, input logic [VW-1:0] d);
        int e;
        bit acc;
        e = cyc;
        if (reset_n) begin
            acc = v && (m_done_cyc < 0);
            if (m_done_cyc == e) begin
                m_active   = 1'b0;
                m_done_cyc = -1;
            end
            if (acc) begin
                hist[e]  = d;
                m_active = 1'b1;
                if (l) begin
                    m_done_cyc = e + FLUSH_LEN;
                end
            end
        end
        cyc = e + 1;
    endtask

    task automatic applyStimulus(input logic v, input logic l, input logic [VW-1:0] d);
        sf_if.s_valid_i = v;
        sf_if.s_last_i  = l;
        sf_if.s_data_i  = d;
        @(posedge clk);
        modelEdge(v, l, d);
        #1;
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'($urandom_range(0, 1)), randVec());
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        #1;
        hist.delete();
        m_active   = 1'b0;
        m_done_cyc = -1;
        checkOutput();
        repeat (3) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randVec());
        reset_n = 1'b1;
    endtask

    task automatic capture(input int t);
        int off;
        off = cyc - t;
        if (off >= 0 && off < 40) begin
            rec_row5[off] = input_o[5*DWIDTH +: DWIDTH];
            rec_res[off]  = res_valid_o;
            rec_en[off]   = enable_o;
            rec_dn[off]   = done_o;
        end
    endtask

    initial begin
        logic [VW-1:0] d;
        int t;

        spots[0]  = '{6,  8'h05, 1'b0, 1'b1, 1'b0};
        spots[1]  = '{7,  8'h15, 1'b0, 1'b1, 1'b0};
        spots[2]  = '{8,  8'h25, 1'b0, 1'b1, 1'b0};
        spots[3]  = '{9,  8'h35, 1'b0, 1'b1, 1'b0};
        spots[4]  = '{10, 8'h00, 1'b0, 1'b1, 1'b0};
        spots[5]  = '{16, 8'h00, 1'b0, 1'b1, 1'b0};
        spots[6]  = '{17, 8'h00, 1'b1, 1'b1, 1'b0};
        spots[7]  = '{20, 8'h00, 1'b1, 1'b1, 1'b0};
        spots[8]  = '{21, 8'h00, 1'b0, 1'b1, 1'b0};
        spots[9]  = '{34, 8'h00, 1'b0, 1'b1, 1'b0};
        spots[10] = '{35, 8'h00, 1'b0, 1'b1, 1'b1};
        spots[11] = '{36, 8'h00, 1'b0, 1'b0, 1'b0};

        reset_n         = 1'b0;
        sf_if.s_valid_i = 1'b0;
        sf_if.s_last_i  = 1'b0;
        sf_if.s_data_i  = '0;
        #2;
        checkOutput();
        repeat (4) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randVec());
        reset_n = 1'b1;
        idleCycles(2);

        $display("[TB] single vector");
        for (int r = 0; r < ARRAY_SIZE; r++) d[r*DWIDTH +: DWIDTH] = 8'(r + 1);
        applyStimulus(1'b1, 1'b1, d);
        idleCycles(35);

        $display("[TB] back-to-back stream");
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < ARRAY_SIZE; r++) d[r*DWIDTH +: DWIDTH] = 8'(16 * k + r);
            applyStimulus(1'b1, k == 3, d);
            capture(t);
        end
        while (cyc - t < 39) begin
            applyStimulus(1'b0, 1'b0, randVec());
            capture(t);
        end
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("b2b_row5_off%0d", spots[i].off), VW'(rec_row5[spots[i].off]), VW'(spots[i].row5));
            chk($sformatf("b2b_res_off%0d", spots[i].off), VW'(rec_res[spots[i].off]), VW'(spots[i].res));
            chk($sformatf("b2b_en_off%0d", spots[i].off), VW'(rec_en[spots[i].off]), VW'(spots[i].en));
            chk($sformatf("b2b_done_off%0d", spots[i].off), VW'(rec_dn[spots[i].off]), VW'(spots[i].dn));
        end

        $display("[TB] bubble");
        applyStimulus(1'b1, 1'b0, randVec());
        applyStimulus(1'b0, 1'b1, randVec());
        applyStimulus(1'b1, 1'b1, randVec());
        idleCycles(35);

        $display("[TB] flush backpressure");
        applyStimulus(1'b1, 1'b1, randVec());
        repeat (34) applyStimulus(1'b1, 1'b0, randVec());
        applyStimulus(1'b1, 1'b1, randVec());
        idleCycles(35);

        $display("[TB] mid-job reset");
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, randVec());
        doReset();
        idleCycles(1);
        for (int r = 0; r < ARRAY_SIZE; r++) d[r*DWIDTH +: DWIDTH] = 8'(r + 1);
        applyStimulus(1'b1, 1'b1, d);
        idleCycles(35);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), randVec());
            if (i == 700) doReset();
        end
        applyStimulus(1'b1, 1'b1, randVec());
        idleCycles(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
